// File: rtl/shift_serializer_if.sv
// Handshake and serial-output bundle for shift_serializer.
// The DUT uses the slave modport; the word producer uses master.
interface shift_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, frame_start, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, frame_start, busy
    );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word per frame, one bit per clk.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module shift_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int GAP       = 1
) (
    input  logic               clk,
    input  logic               rst,
    shift_serializer_if.slave  bus
);
`ifdef SERIALIZER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int            CW       = $clog2(FLEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FLEN - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic in_ready;
    logic accept;
    logic nxt_bit;

    assign in_ready = (state_q == ST_IDLE) ||
                      (state_q == ST_SHIFT && cnt_q == CNT_LAST && GAP == 0);
    assign accept   = bus.in_valid && in_ready;

    // shreg holds only the bits not yet presented, so the next bit is always at the exit end.
    always_comb begin
        nxt_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef SERIALIZER_PARITY_EN
        if (cnt_q == CW'(WIDTH - 1)) nxt_bit = par_q;
`endif
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        shreg_d       = shreg_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d         = par_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d       = cnt_q + 1'b1;
                    ser_out_d   = nxt_bit;
                    ser_valid_d = 1'b1;
                    shreg_d     = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                                   : {1'b0, shreg_q[WIDTH-1:1]};
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 4'd1;
            end
            default: ;
        endcase

        // Accept overrides the frame-end transition, which gives back-to-back frames when GAP==0.
        if (accept) begin
            state_d       = ST_SHIFT;
            cnt_d         = '0;
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            ser_out_d     = (MSB_FIRST != 0) ? bus.in_data[WIDTH-1] : bus.in_data[0];
            shreg_d       = (MSB_FIRST != 0) ? {bus.in_data[WIDTH-2:0], 1'b0}
                                             : {1'b0, bus.in_data[WIDTH-1:1]};
`ifdef SERIALIZER_PARITY_EN
            par_d         = ^bus.in_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            gap_q         <= '0;
            shreg_q       <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            shreg_q       <= shreg_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
`ifdef SERIALIZER_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench: DUT A (LSB first, GAP=1) and DUT B (MSB first, GAP=0) share clk/rst.
module tb_shift_serializer;
`ifdef SERIALIZER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_serializer_if #(.WIDTH(8)) bus_a ();
    shift_serializer_if #(.WIDTH(8)) bus_b ();

    shift_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    shift_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [1:0] ea, eb;
    int run_b = 0;
    int last_run_b = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected {frame_start, bit} pairs for one frame.
    task automatic push_frame(input int sel, input logic [7:0] w);
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            e = {(i == 0), (sel == 1) ? w[7-i] : w[i]};
            if (sel == 0) qa.push_back(e); else qb.push_back(e);
        end
`ifdef SERIALIZER_PARITY_EN
        e = {1'b0, ^w};
        if (sel == 0) qa.push_back(e); else qb.push_back(e);
`endif
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic send(input int sel, input logic [7:0] w);
        int t = 0;
        if (sel == 0) begin bus_a.in_data = w; bus_a.in_valid = 1'b1; end
        else          begin bus_b.in_data = w; bus_b.in_valid = 1'b1; end
        while (rdy(sel) !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("accept_ready", 32'(rdy(sel)), 32'd1);
        push_frame(sel, w);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus_a.ser_valid === 1'b1) begin
            if (qa.size() == 0) chk("extra_bit_a", 32'(bus_a.ser_valid), 32'd0);
            else begin
                ea = qa.pop_front();
                chk("bit_a", 32'({bus_a.frame_start, bus_a.ser_out}), 32'(ea));
            end
        end
        if (bus_b.ser_valid === 1'b1) begin
            run_b++;
            if (qb.size() == 0) chk("extra_bit_b", 32'(bus_b.ser_valid), 32'd0);
            else begin
                eb = qb.pop_front();
                chk("bit_b", 32'({bus_b.frame_start, bus_b.ser_out}), 32'(eb));
            end
        end else if (run_b > 0) begin
            last_run_b = run_b;
            run_b = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_data = '0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ser_out",   32'(bus_a.ser_out),     32'd0);
        chk("rst_ser_valid", 32'(bus_a.ser_valid),   32'd0);
        chk("rst_fs",        32'(bus_a.frame_start), 32'd0);
        chk("rst_busy",      32'(bus_a.busy),        32'd0);
        chk("rst_ready",     32'(bus_a.in_ready),    32'd1);
        chk("rst_ready_b",   32'(bus_b.in_ready),    32'd1);
        chk("rst_busy_b",    32'(bus_b.busy),        32'd0);

        // Single frame with one-cycle gap.
        send(0, 8'hA5);
        bus_a.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("gap_ser_valid", 32'(bus_a.ser_valid), 32'd0);
        chk("gap_ser_out",   32'(bus_a.ser_out),   32'd0);
        chk("gap_ready",     32'(bus_a.in_ready),  32'd0);
        chk("gap_busy",      32'(bus_a.busy),      32'd1);
        @(negedge clk);
        chk("post_gap_ready", 32'(bus_a.in_ready), 32'd1);
        chk("post_gap_busy",  32'(bus_a.busy),     32'd0);

        // Back-to-back on GAP=0; the second word is held on in_data during the first frame.
        send(1, 8'hFF);
        send(1, 8'h00);
        bus_b.in_valid = 1'b0;
        repeat (FLEN + 4) @(negedge clk);
        chk("b2b_run_len", 32'(last_run_b), 32'(2 * FLEN));
        send(1, 8'h07);
        send(1, 8'h03);
        send(1, 8'hA5);
        bus_b.in_valid = 1'b0;
        repeat (FLEN + 4) @(negedge clk);
        chk("b2b_run_len3", 32'(last_run_b), 32'(3 * FLEN));

        // Parity-relevant words, with in_valid/in_data churn while busy.
        send(0, 8'h07);
        for (int i = 0; i < 5; i++) begin
            bus_a.in_valid = 1'($urandom_range(0, 1));
            bus_a.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus_a.in_valid = 1'b0;
        repeat (FLEN) @(negedge clk);
        send(0, 8'h03);
        bus_a.in_valid = 1'b0;
        repeat (FLEN + 3) @(negedge clk);

        // Reset mid-frame at bit 4, then a clean frame.
        send(0, 8'h3C);
        bus_a.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ser_valid", 32'(bus_a.ser_valid),   32'd0);
        chk("midrst_busy",      32'(bus_a.busy),        32'd0);
        chk("midrst_ser_out",   32'(bus_a.ser_out),     32'd0);
        chk("midrst_fs",        32'(bus_a.frame_start), 32'd0);
        qa.delete();
        rst = 1'b0;
        send(0, 8'h81);
        bus_a.in_valid = 1'b0;
        repeat (FLEN + 3) @(negedge clk);

        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
